dot_product_seq_ctrl: RTL
=========================

DOT_PRODUCT_SEQ_CTRL -- requirements
Module: dot_product_seq_ctrl

Interface
REQ-001 Parameter N, default 4: maximum vector length (elements per operand).
REQ-002 Parameter DW, default 8: signed element width.
REQ-003 Localparam LW = $clog2(N+1): length-field width; AW = 2*DW + $clog2(N): accumulator/result width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 in_valid  input  1  operand set and length presented.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 inp1  input  signed DW x [0:N-1]  operand vector A.
REQ-009 inp2  input  signed DW x [0:N-1]  operand vector B.
REQ-010 len  input  LW  number of active elements, counted from index 0.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sums  output  signed AW  dot product of the first len elements.
REQ-014 err_len  output  1  len exceeded N for the current result.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 FSM states: IDLE, RUN, DONE. The block SHALL use one shared signed multiplier, one product per cycle.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture inp1, inp2, len into registers, clear accumulator and index, then go RUN (len 1..N), DONE (len=0), or RUN with effective length N and err_len=1 (len>N).
REQ-018 RUN: each cycle acc <= acc + A[idx]*B[idx] (full signed, sign-extended to AW, no truncation or saturation); idx increments; after the product at idx = eff_len-1, go DONE.
REQ-019 Latency: handshake in cycle 0; out_valid SHALL rise in cycle eff_len+1 (len=0: cycle 1).
REQ-020 DONE: out_valid=1; sums and err_len held stable until out_valid&&out_ready, then go IDLE next cycle.
REQ-021 in_ready SHALL be 0 in RUN and DONE; inputs changing outside IDLE SHALL have no effect.
REQ-022 sums SHALL show 0 outside DONE; err_len SHALL be 0 outside DONE.
REQ-023 len=0 SHALL produce sums=0, err_len=0.
REQ-024 Minimum operation period: eff_len+2 cycles (no back-to-back overlap of DONE and capture).
REQ-025 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-026 Reset assertion SHALL asynchronously force IDLE, acc=0, idx=0, captured registers=0, in_ready=1 after deassertion, out_valid=0, sums=0, err_len=0, busy=0.
REQ-027 Reset mid-RUN or mid-DONE SHALL abort the operation; no result is delivered.
REQ-028 Reset deassertion SHALL be synchronised by the integrating system; the block has no internal synchroniser.

Structure
REQ-029 Package dot_product_pkg SHALL hold default N and DW, the state enum type (IDLE/RUN/DONE), and a function computing AW.
REQ-030 One sub-module mac_unit (signed DW x DW multiply, AW accumulate, clear and enable inputs) SHALL hold the accumulator; the FSM, index counter and operand registers stay in dot_product_seq_ctrl.

Verification
REQ-031 N=4, DW=8: A={1,2,3,4}, B={5,6,7,8}, len=4, out_ready=1 -> out_valid in cycle 5, sums=70, err_len=0.
REQ-032 A={-128,-128,-128,-128}, B={-128,-128,-128,-128}, len=4 -> sums=65536 (no overflow at AW=18); A={127,...}, B={-128,...} -> sums=-65024.
REQ-033 A={1,2,3,4}, B={1,1,1,1}, len=2 -> sums=3 in cycle 3; len=0 -> sums=0 in cycle 1; len=7 -> sums=10, err_len=1.
REQ-034 Result ready with out_ready=0 for 5 cycles -> out_valid and sums stable, in_ready=0 throughout, inputs toggling ignored; accept then in_ready=1 next cycle.
REQ-035 Reset pulsed in cycle 2 of a len=4 operation -> all outputs reset immediately, no out_valid; following operation A={2,2,2,2}, B={3,3,3,3} -> sums=24.
REQ-036 Back-to-back operations with in_valid held high -> each result correct, period eff_len+2 cycles, no operand mixing.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared definitions for the sequential dot-product block.
//   N_DEF / DW_DEF : default vector length and element width
//   state_e        : controller state encoding
//   calc_aw()      : accumulator width that holds N full DW x DW products
package dot_product_pkg;

   localparam int N_DEF  = 4;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // A product needs 2*DW bits; summing up to N of them adds clog2(N) bits.
   function automatic int calc_aw(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/dot_product_seq_ctrl_mac.sv
// mac_unit: single shared signed multiplier feeding an accumulator.
//   clk_i  : clock          rst_ni : async active-low reset
//   clr_i  : zero the accumulator (takes priority over en_i)
//   en_i   : add a_i*b_i into the accumulator this cycle
//   a_i/b_i: signed DW-bit operands
//   acc_o  : signed AW-bit running sum
module mac_unit #(
   parameter int DW = 8,
   parameter int AW = 18
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic signed [DW-1:0] a_i,
   input  logic signed [DW-1:0] b_i,
   output logic signed [AW-1:0] acc_o
);

   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]   acc_q, acc_d;

   // Full-width product; signed cast sign-extends it to the accumulator.
   assign prod = a_i * b_i;

   always_comb begin
      acc_d = acc_q;
      if (clr_i)     acc_d = '0;
      else if (en_i) acc_d = acc_q + AW'(prod);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_q <= '0;
      else         acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_seq_ctrl.sv
// Sequential dot product: captures two N-element signed vectors and a length,
// then accumulates one product per cycle through a shared mac_unit.
//   clk, reset (async active-low)
//   in_valid/in_ready   : operand handshake (inp1, inp2, len)
//   out_valid/out_ready : result handshake (sums, err_len)
//   busy                : high while an operation is in flight (RUN or DONE)
module dot_product_seq_ctrl
   import dot_product_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int DW = DW_DEF,
   localparam int LW = $clog2(N + 1),
   localparam int AW = calc_aw(N, DW)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [0:N-1][DW-1:0]      inp1,
   input  logic [0:N-1][DW-1:0]      inp2,
   input  logic [LW-1:0]             len,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [AW-1:0]      sums,
   output logic                      err_len,
   output logic                      busy
);

   state_e               state_q, state_d;
   logic [0:N-1][DW-1:0] a_q, b_q;
   logic [LW-1:0]        len_q, len_d;
   logic [LW-1:0]        idx_q, idx_d;
   logic                 err_q, err_d;
   logic                 capture;
   logic signed [DW-1:0] a_sel, b_sel;
   logic signed [AW-1:0] acc;

   assign capture = in_valid && (state_q == IDLE);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (capture) state_d = (len == '0) ? DONE : RUN;
         RUN:  if (idx_q == len_q - LW'(1)) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: result fields are forced to zero outside DONE.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      sums      = (state_q == DONE) ? acc : '0;
      err_len   = (state_q == DONE) ? err_q : 1'b0;
   end

   // Datapath next-state: oversize lengths are clamped to N and flagged.
   always_comb begin
      len_d = len_q;
      err_d = err_q;
      idx_d = idx_q;
      if (capture) begin
         idx_d = '0;
         if (len > LW'(N)) begin
            len_d = LW'(N);
            err_d = 1'b1;
         end else begin
            len_d = len;
            err_d = 1'b0;
         end
      end else if (state_q == RUN) begin
         idx_d = idx_q + LW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q   <= '0;
         b_q   <= '0;
         len_q <= '0;
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (capture) begin
            a_q <= inp1;
            b_q <= inp2;
         end
         len_q <= len_d;
         idx_q <= idx_d;
         err_q <= err_d;
      end
   end

   // Element select by compare rather than direct indexing: idx can reach N
   // after the last product, which would be out of range.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == LW'(i)) begin
            a_sel = a_q[i];
            b_sel = b_q[i];
         end
      end
   end

   mac_unit #(.DW(DW), .AW(AW)) u_mac (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (capture),
      .en_i   (state_q == RUN),
      .a_i    (a_sel),
      .b_i    (b_sel),
      .acc_o  (acc)
   );

endmodule
